multiplicador: RTL and testbench
================================

# multiplicador

Sequential shift-and-add unsigned multiplier for the ALU, the inverse datapath of the restoring divider. It sits beside the divider in the ALU operation mux. It shares the same `init`/`done` handshake, so the ALU controller drives both blocks identically. One multiplier bit is processed per CHECK/[ADD]/SHIFT pass, and the result is held on `PP` until the next accepted start.

## Interface
- `WIDTH`, default 3: operand width; the product is `2*WIDTH` bits.
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `MD`  in  WIDTH  multiplicand, sampled on the accept edge only.
- `MR`  in  WIDTH  multiplier, sampled on the accept edge only.
- `init`  in  1  start request, rising-edge triggered.
- `PP`  out  2*WIDTH  product (registered).
- `done`  out  1  result-valid flag (registered, sticky).

## Operation
- **Reset** (`rst_n`=0 at a clock edge):
  - state=IDLE, `PP`=0, `done`=0, internal `MD_r`/`MR_r`/`count`=0.
  - `init_q`=1, so `init` must be seen low before the first start.
- **Start detect:** `start = init & ~init_q`; `init_q` registers `init` every cycle. Holding `init` high never retriggers.
- **States:** IDLE, CHECK, ADD, SHIFT, END.
  - IDLE, `start`=1: load `MD_r`={WIDTH'b0, MD}, `MR_r`=MR, `PP`=0, `count`=WIDTH, `done`=0; go to CHECK.
  - IDLE, `start`=0: hold all outputs.
  - CHECK: if `MR_r[0]` go to ADD, else go to SHIFT. No datapath change.
  - ADD: `PP` = `PP` + `MD_r`, modulo 2^(2*WIDTH); no overflow is possible. Go to SHIFT.
  - SHIFT: `MD_r` <<= 1, `MR_r` >>= 1, `count` -= 1. If `count` was 1, go to END; else go to CHECK.
  - END: `done`=1; go to IDLE.
  - Undefined encodings go to IDLE.
- **Busy window:** `start` is ignored outside IDLE. `init_q` still tracks `init`, so an edge that occurs while busy is lost and is not queued.
- **Output validity:** `PP` changes during the operation and is valid only while `done`=1. `done` clears on the next accepted start or on reset.
- **Operand changes:** `MD`/`MR` may change freely after the accept edge without affecting the result.
- **Reset mid-operation:** aborts immediately to the reset values. No partial result is retained.

## Timing
- Accept edge E0 is the IDLE cycle with `start`=1.
- Per multiplier bit: 2 cycles (CHECK, SHIFT), plus 1 (ADD) if the bit is 1.
- `done` rises at edge E0 + 2*WIDTH + popcount(MR) + 1.
  - WIDTH=3: MR=0 gives 7 cycles; MR=7 gives 10 cycles.
- The earliest next accept is the edge after `done` rises, i.e. END→IDLE then IDLE with `start`. This requires `init` to have dropped at least one cycle earlier.
- No combinational path from inputs to outputs.

## Structure
- Shared package `alu_pkg`:
  - state encoding constants (IDLE=0, CHECK=1, ADD=2, SHIFT=3, END=4; 3-bit state);
  - `WIDTH` default, so the divider and multiplier agree.
- `count` width: $clog2(WIDTH+1).
- Sub-module `init_edge` (in: `clk`, `rst_n`, `init`; out: `start`):
  - registers `init_q` with reset value 1;
  - reused by the divider's next revision.
- Remaining FSM and datapath: single always block per register group, nonblocking assignments only.

## Test plan
- **Basic multiply:** reset, `init` low 2 cycles, MD=3, MR=5, `init` pulse.
  - `PP`=15, `done` rises 9 cycles after the accept edge.
- **Corner multiplies:**
  - MD=7, MR=7: `PP`=49 after 10 cycles.
  - MD=0, MR=7: `PP`=0 after 10 cycles.
  - MD=7, MR=0: `PP`=0 after 7 cycles.
- **No retrigger:** hold `init` high through and after `done`.
  - Exactly one operation; `done` stays 1 and `PP` is stable for 20 cycles.
- **Busy-window start:** a second `init` edge 3 cycles into an operation with new operands.
  - It is ignored; the first result is correct.
  - A fresh edge after `done` runs the new product (6×4 → 24, `done` cleared on accept).
- **Reset mid-operation:** `rst_n` low at cycle 4 of 7×6.
  - Next edge gives `PP`=0, `done`=0, state IDLE.
  - `init` still high after reset does not start until it toggles low→high.
- **Exhaustive sweep:** all 64 WIDTH=3 operand pairs back-to-back.
  - `PP` = MD*MR.
  - Latency = 7 + popcount(MR).

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- definitions shared by the ALU sequential arithmetic blocks
// (restoring divider and shift-and-add multiplier).
//   ALU_WIDTH   : default operand width, so both blocks agree
//   alu_state_e : 3-bit FSM state encoding common to both blocks
package alu_pkg;

  localparam int ALU_WIDTH = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_END   = 3'd4
  } alu_state_e;

endpackage

// File: rtl/init_edge.sv
// init_edge -- rising-edge detector for the init/done start handshake.
// Ports:
//   clk   in  system clock
//   rst_n in  synchronous active-low reset
//   init  in  start request level
//   start out one-cycle pulse when init goes low->high
// init_q resets to 1, so an init that is already high when reset is
// released does not start an operation; it must go low first.
module init_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  output logic start
);

  logic init_q;
  logic init_d;

  // Next value of the init history flop: simply follow init.
  always_comb begin
    init_d = init;
  end

  // Init history register, reset high to suppress a start out of reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_q <= 1'b1;
    end else begin
      init_q <= init_d;
    end
  end

  assign start = init & ~init_q;

endmodule

// File: rtl/multiplicador.sv
// multiplicador -- sequential shift-and-add unsigned multiplier.
// One multiplier bit per CHECK/[ADD]/SHIFT pass; the product is held on PP
// with done=1 until the next accepted start.
// Ports:
//   clk   in  system clock (rising edge)
//   rst_n in  synchronous active-low reset
//   MD    in  multiplicand, sampled on the accept edge only
//   MR    in  multiplier, sampled on the accept edge only
//   init  in  start request, rising-edge triggered
//   PP    out 2*WIDTH-bit product (registered)
//   done  out result-valid flag (registered, sticky)
module multiplicador
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   MD,
  input  logic [WIDTH-1:0]   MR,
  input  logic               init,
  output logic [2*WIDTH-1:0] PP,
  output logic               done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic start;

  alu_state_e state_q, state_d;

  logic [2*WIDTH-1:0] md_q, md_d;
  logic [WIDTH-1:0]   mr_q, mr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] pp_q, pp_d;
  logic               done_q, done_d;

  init_edge u_init_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (init),
    .start (start)
  );

  // Next-state and datapath update; every register holds unless its state acts.
  always_comb begin
    state_d = state_q;
    md_d    = md_q;
    mr_d    = mr_q;
    count_d = count_q;
    pp_d    = pp_q;
    done_d  = done_q;

    case (state_q)
      ST_IDLE: begin
        // start is only honoured here; edges while busy are dropped.
        if (start) begin
          md_d    = {{WIDTH{1'b0}}, MD};
          mr_d    = MR;
          pp_d    = {(2*WIDTH){1'b0}};
          count_d = CNT_W'(WIDTH);
          done_d  = 1'b0;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        if (mr_q[0]) begin
          state_d = ST_ADD;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_ADD: begin
        // md_q is at most (2^WIDTH-1)<<(WIDTH-1); the sum cannot wrap.
        pp_d    = pp_q + md_q;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        md_d    = md_q << 1;
        mr_d    = mr_q >> 1;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d = ST_END;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_END: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_q    <= {(2*WIDTH){1'b0}};
      mr_q    <= {WIDTH{1'b0}};
      count_q <= {CNT_W{1'b0}};
      pp_q    <= {(2*WIDTH){1'b0}};
      done_q  <= 1'b0;
    end else begin
      md_q    <= md_d;
      mr_q    <= mr_d;
      count_q <= count_d;
      pp_q    <= pp_d;
      done_q  <= done_d;
    end
  end

  assign PP   = pp_q;
  assign done = done_q;

endmodule

// File: tb/tb_multiplicador.sv
// tb_multiplicador -- self-checking bench for multiplicador (WIDTH=3).
// Expected products and latencies come from plain arithmetic:
// product = MD*MR, latency = 2*WIDTH + popcount(MR) + 1 cycles after accept.
module tb_multiplicador;

  localparam int W = 3;

  logic           clk;
  logic           rst_n;
  logic           init;
  logic [W-1:0]   MD;
  logic [W-1:0]   MR;
  logic [2*W-1:0] PP;
  logic           done;

  int n_vec = 0;
  int n_err = 0;

  multiplicador #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .MD    (MD),
    .MR    (MR),
    .init  (init),
    .PP    (PP),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_latency(input int mr);
    int ones;
    ones = 0;
    for (int b = 0; b < W; b++) begin
      if (((mr >> b) & 1) == 1) ones++;
    end
    return 2 * W + ones + 1;
  endfunction

  // mode 0: normal; 1: hold init high through and after done;
  // 2: extra init edge with new operands 3 cycles into the operation.
  task automatic run_mult(input int md, input int mr, input int mode, input string tag);
    int lat;
    int exp_p;
    int exp_lat;
    exp_p   = md * mr;
    exp_lat = ref_latency(mr);
    lat     = 0;
    if (init) begin
      init = 1'b0;
      @(posedge clk); #1;
    end
    MD   = W'(md);
    MR   = W'(mr);
    init = 1'b1;
    @(posedge clk); #1;  // accept edge
    check_val({tag, "_accept_done"}, 64'(done), 64'd0);
    check_val({tag, "_accept_pp"}, 64'(PP), 64'd0);
    // operands are free to change after the accept edge
    MD = W'($urandom);
    MR = W'($urandom);
    if (mode != 1) init = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (mode == 2 && k == 3) begin
        MD   = W'(6);
        MR   = W'(4);
        init = 1'b1;
      end
    end
    check_val({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check_val({tag, "_pp"}, 64'(PP), 64'(exp_p));
    if (mode == 1) begin
      for (int c = 0; c < 20; c++) begin
        @(posedge clk); #1;
        check_val({tag, "_hold_done"}, 64'(done), 64'd1);
        check_val({tag, "_hold_pp"}, 64'(PP), 64'(exp_p));
      end
    end
  endtask

  task automatic reset_mid();
    if (init) begin
      init = 1'b0;
      @(posedge clk); #1;
    end
    MD   = W'(7);
    MR   = W'(6);
    init = 1'b1;
    @(posedge clk); #1;  // accept edge
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("rstmid_pp", 64'(PP), 64'd0);
    check_val("rstmid_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    // init still high: no start until it toggles
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      check_val("rstmid_nostart_done", 64'(done), 64'd0);
      check_val("rstmid_nostart_pp", 64'(PP), 64'd0);
    end
    run_mult(7, 6, 0, "rstmid_rerun");
  endtask

  initial begin
    rst_n = 1'b0;
    init  = 1'b0;
    MD    = '0;
    MR    = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_pp", 64'(PP), 64'd0);
    check_val("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_mult(3, 5, 0, "basic");
    run_mult(7, 7, 0, "c77");
    run_mult(0, 7, 0, "c07");
    run_mult(7, 0, 0, "c70");
    run_mult(5, 3, 1, "hold");
    run_mult(2, 3, 2, "busy");
    run_mult(6, 4, 0, "fresh");
    reset_mid();

    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        run_mult(a, b, 0, "sweep");
      end
    end

    for (int r = 0; r < 30; r++) begin
      run_mult(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
